// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants, the pointer type and the Gray/binary conversion helpers.
package fifo_pkg;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2**ADDR_W;
    localparam int PTR_W  = ADDR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/ptr_sync_chain.sv
// WIDTH x SYNC_STAGES clock-domain-crossing flop chain with asynchronous active-low reset.
// Reused by both pointer synchronizers of the async FIFO.
module ptr_sync_chain #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("ptr_sync_chain: SYNC_STAGES must be at least 2");
        end
    endgenerate

    // Synchronizer flops: must stay adjacent and must not be retimed or merged.
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/w_rptr_sync.sv
// Write-domain read-pointer synchronizer: synced Gray pointer, binary form, free-slot count, advance pulse.
// Optional Gray-violation / clamp checker enabled by defining W_RPTR_SYNC_GRAY_CHECK_EN.
module w_rptr_sync
    import fifo_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PTR_W-1:0] r_ptr_async,
    input  logic [PTR_W-1:0] w_ptr,
    input  logic             err_clr,
    output logic [PTR_W-1:0] r_ptr_sync,
    output logic [PTR_W-1:0] r_bin_sync,
    output logic [PTR_W-1:0] free_cnt,
    output logic             advanced,
    output logic             gray_err
);

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    ptr_t w_sync;
    ptr_t r_prev_sync;
    ptr_t r_r_bin;
    ptr_t r_free_cnt;
    logic r_advanced;

    ptr_t w_r_bin;
    ptr_t w_w_bin;
    ptr_t w_occ;
    logic w_clamp;
    ptr_t w_free_next;

    ptr_sync_chain #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_chain (
        .clk (clk),
        .rst (rst),
        .i_d (r_ptr_async),
        .o_q (w_sync)
    );

    assign r_ptr_sync = w_sync;

    // Modulo-2**PTR_W subtraction handles read-pointer wrap without a special case.
    always_comb begin
        w_r_bin     = gray2bin(w_sync);
        w_w_bin     = gray2bin(w_ptr);
        w_occ       = w_w_bin - w_r_bin;
        w_clamp     = (w_occ > DEPTH_P);
        w_free_next = w_clamp ? '0 : (DEPTH_P - w_occ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_sync <= '0;
            r_r_bin     <= '0;
            r_free_cnt  <= DEPTH_P;
            r_advanced  <= 1'b0;
        end else begin
            r_prev_sync <= w_sync;
            r_r_bin     <= w_r_bin;
            r_free_cnt  <= w_free_next;
            r_advanced  <= (w_sync != r_prev_sync);
        end
    end

    assign r_bin_sync = r_r_bin;
    assign free_cnt   = r_free_cnt;
    assign advanced   = r_advanced;

`ifdef W_RPTR_SYNC_GRAY_CHECK_EN
    ptr_t w_diff;
    logic w_multi_bit;
    logic r_gray_err;

    // More than one bit set in the step means the synchronized pointer skipped a Gray code.
    assign w_diff      = w_sync ^ r_prev_sync;
    assign w_multi_bit = ((w_diff & (w_diff - ptr_t'(1))) != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gray_err <= 1'b0;
        end else if (w_multi_bit || w_clamp) begin
            r_gray_err <= 1'b1;
        end else if (err_clr) begin
            r_gray_err <= 1'b0;
        end
    end

    assign gray_err = r_gray_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign gray_err         = 1'b0;
`endif

endmodule

// File: tb/tb_w_rptr_sync.sv
// Self-checking bench for w_rptr_sync: settled-state vector table plus cycle-exact corner sequences.
module tb_w_rptr_sync;

`ifdef W_RPTR_SYNC_GRAY_CHECK_EN
    localparam bit GCHK = 1'b1;
`else
    localparam bit GCHK = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] r_ptr_async;
    logic [3:0] w_ptr;
    logic       err_clr;
    logic [3:0] r_ptr_sync;
    logic [3:0] r_bin_sync;
    logic [3:0] free_cnt;
    logic       advanced;
    logic       gray_err;

    int checks = 0;
    int errors = 0;

    w_rptr_sync #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .r_ptr_async (r_ptr_async),
        .w_ptr       (w_ptr),
        .err_clr     (err_clr),
        .r_ptr_sync  (r_ptr_sync),
        .r_bin_sync  (r_bin_sync),
        .free_cnt    (free_cnt),
        .advanced    (advanced),
        .gray_err    (gray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r_in;
        logic [3:0] w_in;
        logic [3:0] e_rsync;
        logic [3:0] e_rbin;
        logic [3:0] e_free;
        logic       e_adv;
        logic       e_err;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] rsync;
        logic [3:0] rbin;
        logic [3:0] free;
        logic       adv;
        logic       err;
    } exp_t;

    vec_t vecs [9];
    exp_t exp_q [$];

    task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input string nm, input logic [3:0] rs, input logic [3:0] rb,
                            input logic [3:0] fr, input logic ad, input logic er);
        exp_t e;
        e.name = nm; e.rsync = rs; e.rbin = rb; e.free = fr; e.adv = ad; e.err = er;
        exp_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            cmp({e.name, ".r_ptr_sync"}, r_ptr_sync, e.rsync);
            cmp({e.name, ".r_bin_sync"}, r_bin_sync, e.rbin);
            cmp({e.name, ".free_cnt"},   free_cnt,   e.free);
            cmp({e.name, ".advanced"},   {3'b0, advanced}, {3'b0, e.adv});
            cmp({e.name, ".gray_err"},   {3'b0, gray_err}, {3'b0, e.err});
            $display("txn %-14s rsync=%h rbin=%h free=%0d adv=%b err=%b",
                     e.name, r_ptr_sync, r_bin_sync, free_cnt, advanced, gray_err);
        end
    endtask

    // Advance n edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        r_ptr_async = 4'h0;
        w_ptr = 4'h0;
        err_clr = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          r_in   w_in   rsync  rbin   free   adv  err
        vecs[0] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'd7, 1'b0, 1'b0};
        vecs[1] = '{4'h0, 4'h3, 4'h0, 4'h0, 4'd6, 1'b0, 1'b0};
        vecs[2] = '{4'h0, 4'h7, 4'h0, 4'h0, 4'd3, 1'b0, 1'b0};
        vecs[3] = '{4'h1, 4'h7, 4'h1, 4'h1, 4'd4, 1'b0, 1'b0};
        vecs[4] = '{4'h1, 4'hC, 4'h1, 4'h1, 4'd1, 1'b0, 1'b0};
        vecs[5] = '{4'h3, 4'hC, 4'h3, 4'h2, 4'd2, 1'b0, 1'b0};
        vecs[6] = '{4'h2, 4'hC, 4'h2, 4'h3, 4'd3, 1'b0, 1'b0};
        vecs[7] = '{4'h2, 4'hE, 4'h2, 4'h3, 4'd0, 1'b0, 1'b0};
        vecs[8] = '{4'h6, 4'hE, 4'h6, 4'h4, 4'd1, 1'b0, 1'b0};

        rst = 1'b0;
        r_ptr_async = 4'h0;
        w_ptr = 4'h0;
        err_clr = 1'b0;

        #12;
        push_exp("reset", 4'h0, 4'h0, 4'd8, 1'b0, 1'b0);
        check_pop();
        @(negedge clk);
        rst = 1'b1;
        step(4);
        push_exp("post_release", 4'h0, 4'h0, 4'd8, 1'b0, 1'b0);
        check_pop();

        for (int i = 0; i < 9; i++) begin
            r_ptr_async = vecs[i].r_in;
            w_ptr       = vecs[i].w_in;
            push_exp($sformatf("vec%0d", i), vecs[i].e_rsync, vecs[i].e_rbin,
                     vecs[i].e_free, vecs[i].e_adv, vecs[i].e_err);
            step(5);
            check_pop();
        end

        // Reset asserted mid-cycle must act without a clock edge.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        push_exp("async_reset", 4'h0, 4'h0, 4'd8, 1'b0, 1'b0);
        check_pop();
        r_ptr_async = 4'h0;
        w_ptr = 4'h0;
        step(2);
        @(negedge clk);
        rst = 1'b1;
        step(3);
        push_exp("release_hold", 4'h0, 4'h0, 4'd8, 1'b0, 1'b0);
        check_pop();

        // Latency: sync after 2 edges, bin/advanced after 3.
        w_ptr = 4'h1;
        step(3);
        cmp("lat.free_pre", free_cnt, 4'd7);
        r_ptr_async = 4'h1;
        step(1);
        cmp("lat.sync_e0", r_ptr_sync, 4'h0);
        step(1);
        cmp("lat.sync_e1", r_ptr_sync, 4'h1);
        cmp("lat.bin_e1", r_bin_sync, 4'h0);
        cmp("lat.adv_e1", {3'b0, advanced}, 4'h0);
        step(1);
        cmp("lat.adv_e2", {3'b0, advanced}, 4'h1);
        cmp("lat.bin_e2", r_bin_sync, 4'h1);
        cmp("lat.free_e2", free_cnt, 4'd8);
        step(1);
        cmp("lat.adv_e3", {3'b0, advanced}, 4'h0);

        // Occupancy: w_ptr path is one cycle.
        do_reset();
        w_ptr = 4'h7;
        step(1);
        cmp("occ.free5", free_cnt, 4'd3);
        w_ptr = 4'hC;
        step(1);
        cmp("occ.free8", free_cnt, 4'd0);
        cmp("occ.err", {3'b0, gray_err}, 4'h0);

        // Clamp: occ 12 > DEPTH.
        w_ptr = 4'hA;
        step(1);
        cmp("clamp.free", free_cnt, 4'd0);
        cmp("clamp.err", {3'b0, gray_err}, {3'b0, GCHK});
        step(3);
        cmp("clamp.err_hold", {3'b0, gray_err}, {3'b0, GCHK});
        w_ptr = 4'h0;
        step(1);
        cmp("clamp.free_back", free_cnt, 4'd8);
        cmp("clamp.err_sticky", {3'b0, gray_err}, {3'b0, GCHK});
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        cmp("clamp.err_clr", {3'b0, gray_err}, 4'h0);

        // Wrap: r bin 15, w bin 3.
        do_reset();
        w_ptr = 4'h2;
        step(2);
        cmp("wrap.free_pre", free_cnt, 4'd5);
        r_ptr_async = 4'h8;
        push_exp("wrap", 4'h8, 4'hF, 4'd4, 1'b0, 1'b0);
        step(4);
        check_pop();

        // Gray violation 0000 -> 0011.
        do_reset();
        w_ptr = 4'h3;
        step(2);
        cmp("gv.free_pre", free_cnt, 4'd6);
        r_ptr_async = 4'h3;
        step(2);
        cmp("gv.sync_e1", r_ptr_sync, 4'h3);
        cmp("gv.err_e1", {3'b0, gray_err}, 4'h0);
        step(1);
        cmp("gv.err_e2", {3'b0, gray_err}, {3'b0, GCHK});
        step(3);
        cmp("gv.err_hold", {3'b0, gray_err}, {3'b0, GCHK});
        cmp("gv.free", free_cnt, 4'd8);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        cmp("gv.err_clr", {3'b0, gray_err}, 4'h0);

        // Set wins over a simultaneous clear.
        r_ptr_async = 4'h0;
        step(2);
        cmp("sw.err_e1", {3'b0, gray_err}, 4'h0);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        cmp("sw.err_e2", {3'b0, gray_err}, {3'b0, GCHK});
        cmp("sw.free", free_cnt, 4'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/w_rptr_sync.md
# w_rptr_sync

Write-domain read-pointer synchronizer for the 8-entry async FIFO. It moves the read side's Gray-coded pointer into the write clock through a flop chain and hands the result to the write-side full logic. It also derives the binary read pointer and the free-slot count, and flags illegal multi-bit Gray transitions. It sits between the read-domain pointer register and the write-side full/almost-full block.

## Interface
- ADDR_W, 3, FIFO address width; DEPTH = 2**ADDR_W, PTR_W = ADDR_W+1
- SYNC_STAGES, 2, synchronizer flop count; legal values ≥ 2
- clk  input  1  write-domain clock
- rst  input  1  asynchronous, active-low reset
- r_ptr_async  input  PTR_W  Gray read pointer from the read clock domain, unsynchronized
- w_ptr  input  PTR_W  local Gray write pointer, already in the clk domain
- err_clr  input  1  clears gray_err
- r_ptr_sync  output  PTR_W  synchronized Gray read pointer; feeds the full comparison
- r_bin_sync  output  PTR_W  binary form of r_ptr_sync, registered
- free_cnt  output  PTR_W  free slots, range 0..DEPTH, registered
- advanced  output  1  one-cycle pulse when the synchronized read pointer changes
- gray_err  output  1  sticky flag for a Gray-code violation

## Operation
- Chain: r_ptr_async is sampled on every posedge clk into stage 1, then shifts through SYNC_STAGES flops. r_ptr_sync = last stage.
- Hold register: prev_sync captures r_ptr_sync every cycle.
- r_bin_sync is registered as gray2bin(r_ptr_sync).
- w_bin is computed combinationally as gray2bin(w_ptr).
- occ = (w_bin − gray2bin(r_ptr_sync)) mod 2**PTR_W.
- free_cnt is registered as DEPTH − occ when occ ≤ DEPTH, otherwise 0 (clamp for an inconsistent pointer pair).
- advanced is registered as (r_ptr_sync != prev_sync).
- Wrap-around: all pointer arithmetic is modulo 2**PTR_W. No special case is needed when r_bin wraps from 15 to 0.
- Simultaneous pointer events: when w_ptr and the synchronized read pointer change in the same cycle, free_cnt reflects both values in the next cycle.
- Reset, asserted at any time, takes effect immediately regardless of clk:
  - All chain flops, prev_sync, r_ptr_sync, r_bin_sync, advanced and gray_err go to 0.
  - free_cnt goes to DEPTH (8).
  - On release, the first sample is taken at the next posedge.

## Timing
- Latency from r_ptr_async to r_ptr_sync is SYNC_STAGES edges: 2 by default.
- r_bin_sync, free_cnt and advanced follow r_ptr_sync by 1 more cycle: SYNC_STAGES+1 total.
- The w_ptr → free_cnt path takes 1 cycle.
- No handshake: the outputs are valid every cycle after reset release.
- For the full logic, free_cnt is pessimistic; this pessimism is permitted:
  - The read pointer is stale by up to SYNC_STAGES+1 cycles, which only under-reports free slots.
  - free_cnt never over-reports.

## Configuration
- Macro: W_RPTR_SYNC_GRAY_CHECK_EN.
- Defined:
  - A check is registered each cycle: popcount(r_ptr_sync ^ prev_sync) > 1 sets gray_err.
  - gray_err stays set until err_clr is high on a clock edge.
  - If err_clr and a new violation occur in the same cycle, set wins.
  - The occ > DEPTH clamp case also sets gray_err.
- Undefined:
  - gray_err is tied to 0 and err_clr is ignored.
  - No check logic is synthesized; the clamp on free_cnt remains.

## Structure
- Package fifo_pkg holds:
  - localparams ADDR_W, DEPTH, PTR_W
  - typedef ptr_t (logic [PTR_W-1:0])
  - function gray2bin (XOR-prefix reduction)
  - function bin2gray
- Sub-module ptr_sync_chain:
  - Parameterized width × SYNC_STAGES flop chain with async active-low reset.
  - Carries a synthesis attribute marking it as a synchronizer (no retiming, flops kept adjacent).
  - Reusable by the read-side write-pointer synchronizer.

## Test plan
- Reset:
  - Pull rst low mid-cycle.
  - Outputs must go to 0 immediately, with free_cnt=8; no clock edge is required.
  - Release rst; the outputs must stay at 0 / 8 until r_ptr_async changes.
- Latency:
  - Stimulus: rst high, w_ptr=0000; r_ptr_async 0000→0001 before edge 0.
  - r_ptr_sync=0001 after edge 1.
  - advanced pulses for exactly 1 cycle after edge 2, and r_bin_sync=0001 after edge 2.
- Occupancy:
  - Stimulus: w_ptr=0111 (bin 5), r_ptr_async held at 0000.
  - free_cnt=3; then w_ptr=1100 (bin 8) → free_cnt=0.
- Wrap:
  - Stimulus: r_ptr_async=1000 (bin 15), w_ptr=0010 (bin 3), settled.
  - Required: occ=4, free_cnt=4, with no gray_err.
- Gray violation (macro defined):
  - Stimulus: r_ptr_async 0000→0011.
  - gray_err=1 three cycles later and held; err_clr pulse → 0 next edge.
  - Repeat with the macro undefined: gray_err stays 0.
- Clamp:
  - Stimulus: w_ptr bin 12 (1010), r_ptr bin 0.
  - free_cnt=0, and gray_err=1 when the macro is defined.
